// File: rtl/data_ram_if.sv
// -----------------------------------------------------------------------------
// data_ram_if : CPU <-> data RAM port bundle.
//
// Signals:
//   ram_EN            CPU -> RAM  access request, active-high
//   ram_RW            CPU -> RAM  1 = read, 0 = write
//   ram_address_bus   CPU -> RAM  access address (ADDR_W bits)
//   ram_data_bus_out  CPU -> RAM  write data (DATA_W bits)
//   ram_data_bus_in   RAM -> CPU  registered read data (DATA_W bits)
//   rd_valid          RAM -> CPU  one-cycle strobe, read data updated last edge
//   init_busy         RAM -> CPU  self-initialisation in progress
//   ram_err           RAM -> CPU  sticky: access requested during init
//
// Modports: master = CPU side, slave = RAM side.
// -----------------------------------------------------------------------------
interface data_ram_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
);
    logic              ram_EN;
    logic              ram_RW;
    logic [ADDR_W-1:0] ram_address_bus;
    logic [DATA_W-1:0] ram_data_bus_out;
    logic [DATA_W-1:0] ram_data_bus_in;
    logic              rd_valid;
    logic              init_busy;
    logic              ram_err;

    modport master (
        output ram_EN, ram_RW, ram_address_bus, ram_data_bus_out,
        input  ram_data_bus_in, rd_valid, init_busy, ram_err
    );

    modport slave (
        input  ram_EN, ram_RW, ram_address_bus, ram_data_bus_out,
        output ram_data_bus_in, rd_valid, init_busy, ram_err
    );
endinterface

// File: rtl/data_ram.sv
// -----------------------------------------------------------------------------
// data_ram : single-port 2**ADDR_W x DATA_W data memory for the CPU RAM port.
//
// After reset the memory walks every address once, writing INIT_VAL, while
// init_busy is high. Afterwards it serves one access per clock: writes land
// at the sampling edge, reads are registered with a one-cycle rd_valid strobe.
// Any access requested during initialisation is dropped and sets the sticky
// ram_err flag.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    data_ram_if.slave (ram_EN, ram_RW, ram_address_bus,
//          ram_data_bus_out in; ram_data_bus_in, rd_valid, init_busy,
//          ram_err out)
// -----------------------------------------------------------------------------
module data_ram #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 4,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    data_ram_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_INIT = 1'b0,
        S_IDLE = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  init_cnt, init_cnt_nxt;

    // Storage has no reset: the INIT pass is what gives it a known value.
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               rd_en;
    logic               err_set;

    logic [DATA_W-1:0]  rd_data_p1;
    logic               vld_p1;
    logic               err_p1;

    // ---- FSM state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // ---- FSM next state and access decode ----
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        mem_we       = 1'b0;
        mem_waddr    = bus.ram_address_bus;
        mem_wdata    = bus.ram_data_bus_out;
        rd_en        = 1'b0;
        err_set      = 1'b0;

        case (state)
            S_INIT: begin
                mem_we       = 1'b1;
                mem_waddr    = init_cnt;
                mem_wdata    = INIT_VAL;
                init_cnt_nxt = ADDR_W'(init_cnt + 1'b1);
                // CPU requests are dropped here but remembered as an error.
                err_set      = bus.ram_EN;
                if (init_cnt == '1) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.ram_EN) begin
                    if (bus.ram_RW) begin
                        rd_en  = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt    = S_INIT;
                init_cnt_nxt = '0;
            end
        endcase
    end

    // ---- Array write ----
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ---- Stage p1: registered read data, valid strobe, sticky error ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
            err_p1     <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en) begin
                rd_data_p1 <= mem[bus.ram_address_bus];
            end
            if (err_set) begin
                err_p1 <= 1'b1;
            end
        end
    end

    assign bus.ram_data_bus_in = rd_data_p1;
    assign bus.rd_valid        = vld_p1;
    assign bus.ram_err         = err_p1;
    // state is a flop, so init_busy is a registered output.
    assign bus.init_busy       = (state == S_INIT);

endmodule

// File: tb/tb_data_ram.sv
module tb_data_ram;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    data_ram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    data_ram #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .INIT_VAL(4'b0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.ram_EN           = 1'b0;
        bus.ram_RW           = 1'b0;
        bus.ram_address_bus  = '0;
        bus.ram_data_bus_out = '0;
    endtask

    // Runs the 256-edge init pass after reset release. If inj_edge > 0, a
    // write of 0x5 to 0x20 is presented on that edge.
    task automatic run_init(input int inj_edge);
        for (int i = 1; i <= 256; i++) begin
            if (i == inj_edge) begin
                bus.ram_EN           = 1'b1;
                bus.ram_RW           = 1'b0;
                bus.ram_address_bus  = 8'h20;
                bus.ram_data_bus_out = 4'h5;
            end
            @(posedge clk); #1;
            if (i == inj_edge) begin
                chk("init_err_set", 32'(bus.ram_err), 32'd1);
                chk("init_wr_no_valid", 32'(bus.rd_valid), 32'd0);
                bus.ram_EN = 1'b0;
            end
            if (inj_edge > 0 && i == inj_edge - 1)
                chk("init_err_before", 32'(bus.ram_err), 32'd0);
            if (i == 1)   chk("busy_edge1", 32'(bus.init_busy), 32'd1);
            if (i == 255) chk("busy_edge255", 32'(bus.init_busy), 32'd1);
            if (i == 256) chk("busy_edge256", 32'(bus.init_busy), 32'd0);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [3:0] d);
        bus.ram_EN           = 1'b1;
        bus.ram_RW           = 1'b0;
        bus.ram_address_bus  = a;
        bus.ram_data_bus_out = d;
        @(posedge clk); #1;
        bus.ram_EN = 1'b0;
        chk("wr_no_valid", 32'(bus.rd_valid), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [7:0] a, input logic [3:0] exp);
        bus.ram_EN          = 1'b1;
        bus.ram_RW          = 1'b1;
        bus.ram_address_bus = a;
        @(posedge clk); #1;
        bus.ram_EN = 1'b0;
        chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.ram_data_bus_in), 32'(exp));
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, 32'(bus.rd_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] lfsr;
        idle_bus();

        // Reset values
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_data", 32'(bus.ram_data_bus_in), 32'd0);
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_err", 32'(bus.ram_err), 32'd0);
        chk("rst_busy", 32'(bus.init_busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Clean init then reads of init values
        run_init(0);
        do_read("rd00", 8'h00, 4'h0);
        do_read("rd7f", 8'h7F, 4'h0);
        do_read("rdff", 8'hFF, 4'h0);
        chk("err_clean", 32'(bus.ram_err), 32'd0);

        // Write then read on the very next edge
        do_write(8'h12, 4'hA);
        do_read("rd12", 8'h12, 4'hA);

        // Back-to-back reads
        do_write(8'h00, 4'h3);
        do_write(8'hFF, 4'hC);
        bus.ram_EN = 1'b1;
        bus.ram_RW = 1'b1;
        bus.ram_address_bus = 8'h00;
        @(posedge clk); #1;
        chk("b2b0_valid", 32'(bus.rd_valid), 32'd1);
        chk("b2b0_data", 32'(bus.ram_data_bus_in), 32'h3);
        bus.ram_address_bus = 8'hFF;
        @(posedge clk); #1;
        chk("b2b1_valid", 32'(bus.rd_valid), 32'd1);
        chk("b2b1_data", 32'(bus.ram_data_bus_in), 32'hC);
        bus.ram_address_bus = 8'h01;
        @(posedge clk); #1;
        chk("b2b2_valid", 32'(bus.rd_valid), 32'd1);
        chk("b2b2_data", 32'(bus.ram_data_bus_in), 32'h0);
        bus.ram_EN = 1'b0;
        @(posedge clk); #1;
        chk("b2b_valid_drop", 32'(bus.rd_valid), 32'd0);

        // EN=0 with random other inputs: nothing may change
        do_read("pre_idle", 8'h00, 4'h3);
        lfsr = 16'hACE1;
        for (int i = 0; i < 500; i++) begin
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            bus.ram_EN           = 1'b0;
            bus.ram_RW           = lfsr[0];
            bus.ram_address_bus  = lfsr[8:1];
            bus.ram_data_bus_out = lfsr[12:9];
            @(posedge clk); #1;
            chk("idle_data", 32'(bus.ram_data_bus_in), 32'h3);
            chk("idle_valid", 32'(bus.rd_valid), 32'd0);
        end
        idle_bus();
        do_read("post_idle00", 8'h00, 4'h3);
        do_read("post_idleff", 8'hFF, 4'hC);
        do_read("post_idle12", 8'h12, 4'hA);
        do_read("post_idle01", 8'h01, 4'h0);

        // Access during INIT sets the sticky error and is dropped
        rst_n = 1'b0;
        #1;
        chk("rst2_data", 32'(bus.ram_data_bus_in), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_init(10);
        chk("err_sticky", 32'(bus.ram_err), 32'd1);
        do_read("rd20", 8'h20, 4'h0);
        chk("err_still", 32'(bus.ram_err), 32'd1);

        // Reset mid-operation reruns INIT and wipes written data
        do_write(8'h40, 4'hF);
        do_read("rd40_pre", 8'h40, 4'hF);
        bus.ram_EN = 1'b1;
        bus.ram_RW = 1'b1;
        bus.ram_address_bus = 8'h40;
        @(posedge clk); #1;
        bus.ram_EN = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst3_data", 32'(bus.ram_data_bus_in), 32'd0);
        chk("rst3_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst3_err", 32'(bus.ram_err), 32'd0);
        chk("rst3_busy", 32'(bus.init_busy), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst3_busy_hold", 32'(bus.init_busy), 32'd1);
        rst_n = 1'b1;
        run_init(0);
        do_read("rd40_post", 8'h40, 4'h0);
        do_read("rd12_post", 8'h12, 4'h0);
        chk("err_after_rst", 32'(bus.ram_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
